// File: rtl/mem_inst_sequencer.sv
// Runtime-loadable instruction sequencer for the memory-interface datapath.
// Issues read/shift words over valid/ready and runs wfi/loop internally.
module mem_inst_sequencer #(
  parameter int unsigned INST_WIDTH = 56,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned INST_DEPTH = 1 << ADDR_WIDTH,
  parameter int unsigned ITER_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  LOAD_EN,
  input  logic [ADDR_WIDTH-1:0] LOAD_ADDR,
  input  logic [INST_WIDTH-1:0] LOAD_DATA,
  input  logic                  START,
  input  logic [ITER_WIDTH-1:0] ITER,
  input  logic                  GO,
  output logic [INST_WIDTH-1:0] INST_OUT,
  output logic                  INST_VALID,
  input  logic                  INST_READY,
  output logic                  WAITING,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [ITER_WIDTH-1:0] PASS_CNT
);

  localparam logic [2:0] OP_WFI  = 3'b110;
  localparam logic [2:0] OP_LOOP = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT_GO,
    S_DONE
  } state_t;

  state_t                state, state_d;
  logic [INST_WIDTH-1:0] store [INST_DEPTH];
  logic [ADDR_WIDTH-1:0] pc, pc_d, pc_inc;
  logic [ITER_WIDTH-1:0] rem, rem_d, pass_d;
  logic [INST_WIDTH-1:0] inst, inst_d;
  logic [2:0]            op;
  logic                  valid_d, waiting_d, busy_d, done_d;
  logic                  load_ok;

  assign op      = inst[6:4];
  assign pc_inc  = (pc == ADDR_WIDTH'(INST_DEPTH - 1)) ? '0 : pc + ADDR_WIDTH'(1);
  assign load_ok = LOAD_EN && ((state == S_IDLE) || (state == S_DONE));

  // Instruction store; every entry resets to a bare loop so an empty program halts.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < int'(INST_DEPTH); i++) begin
        store[i] <= INST_WIDTH'(7'h70);
      end
    end else if (load_ok) begin
      store[LOAD_ADDR] <= LOAD_DATA;
    end
  end

  always_comb begin
    state_d = state;
    pc_d    = pc;
    rem_d   = rem;
    pass_d  = PASS_CNT;
    inst_d  = inst;
    case (state)
      S_IDLE, S_DONE: begin
        if (START) begin
          pc_d    = '0;
          pass_d  = '0;
          rem_d   = (ITER == '0) ? '0 : ITER - ITER_WIDTH'(1);
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        inst_d  = store[pc];
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (op == OP_WFI) begin
          state_d = S_WAIT_GO;
        end else if (op == OP_LOOP) begin
          pass_d = PASS_CNT + ITER_WIDTH'(1);
          if (rem == '0) begin
            state_d = S_DONE;
          end else begin
            rem_d   = rem - ITER_WIDTH'(1);
            pc_d    = '0;
            state_d = S_FETCH;
          end
        end else if (INST_VALID && INST_READY) begin
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      S_WAIT_GO: begin
        if (GO) begin
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status flags are registered from the next state so they align with it.
    valid_d   = (state_d == S_ISSUE) && (inst_d[6:4] != OP_WFI) && (inst_d[6:4] != OP_LOOP);
    waiting_d = (state_d == S_WAIT_GO);
    busy_d    = (state_d == S_FETCH) || (state_d == S_ISSUE) || (state_d == S_WAIT_GO);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= S_IDLE;
      pc         <= '0;
      rem        <= '0;
      PASS_CNT   <= '0;
      inst       <= '0;
      INST_VALID <= 1'b0;
      WAITING    <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      rem        <= rem_d;
      PASS_CNT   <= pass_d;
      inst       <= inst_d;
      INST_VALID <= valid_d;
      WAITING    <= waiting_d;
      BUSY       <= busy_d;
      DONE       <= done_d;
    end
  end

  assign INST_OUT = inst;

endmodule

// File: tb/tb_mem_inst_sequencer.sv
// Directed bench for mem_inst_sequencer: vector table plus multi-cycle sequences.
module tb_mem_inst_sequencer;

  logic        CLK = 1'b0;
  logic        RESET, LOAD_EN, START, GO, INST_READY;
  logic [3:0]  LOAD_ADDR;
  logic [55:0] LOAD_DATA, INST_OUT;
  logic [15:0] ITER, PASS_CNT;
  logic        INST_VALID, WAITING, BUSY, DONE;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 CLK = ~CLK;

  mem_inst_sequencer dut (
    .CLK(CLK), .RESET(RESET), .LOAD_EN(LOAD_EN), .LOAD_ADDR(LOAD_ADDR),
    .LOAD_DATA(LOAD_DATA), .START(START), .ITER(ITER), .GO(GO),
    .INST_OUT(INST_OUT), .INST_VALID(INST_VALID), .INST_READY(INST_READY),
    .WAITING(WAITING), .BUSY(BUSY), .DONE(DONE), .PASS_CNT(PASS_CNT)
  );

  typedef struct {
    logic        start;
    logic [15:0] iter;
    logic        load_en;
    logic [3:0]  la;
    logic [55:0] ld;
    logic        e_busy;
    logic        e_done;
    logic        e_valid;
    logic [15:0] e_pass;
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // sel: 0 = INST_VALID, 1 = WAITING, 2 = DONE
  task automatic wait_for(input int sel, input int max, input string name);
    bit ok = 0;
    for (int i = 0; i < max; i++) begin
      if ((sel == 0 && INST_VALID) || (sel == 1 && WAITING) || (sel == 2 && DONE)) begin
        ok = 1;
        break;
      end
      step();
    end
    chk({name, "_timeout"}, 64'(ok), 64'd1);
  endtask

  task automatic add(input logic s, input logic [15:0] it, input logic le, input logic [3:0] a,
                     input logic [55:0] d, input logic b, input logic dn, input logic v,
                     input logic [15:0] p);
    vec_t r;
    r.start = s; r.iter = it; r.load_en = le; r.la = a; r.ld = d;
    r.e_busy = b; r.e_done = dn; r.e_valid = v; r.e_pass = p;
    vecs.push_back(r);
  endtask

  initial begin
    logic [55:0] words[$];
    int          tstamp[$];
    logic [55:0] exp2 [6];

    RESET = 1; LOAD_EN = 0; LOAD_ADDR = 0; LOAD_DATA = 0; START = 0;
    ITER = 0; GO = 0; INST_READY = 1;
    step(); step();
    chk("rst_valid", 64'(INST_VALID), 0);
    chk("rst_busy", 64'(BUSY), 0);
    chk("rst_done", 64'(DONE), 0);
    chk("rst_wait", 64'(WAITING), 0);
    chk("rst_pass", 64'(PASS_CNT), 0);
    chk("rst_out", 64'(INST_OUT), 0);
    RESET = 0;

    // Empty program: ITER=1, ITER=0, ITER=5 (with an ignored START), then load.
    add(1, 1, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 0, 1);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 1);
    add(1, 5, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 1);
    add(1, 1, 0, 0, 0, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 0, 0, 2);
    add(0, 0, 0, 0, 0, 1, 0, 0, 2);
    add(0, 0, 0, 0, 0, 1, 0, 0, 3);
    add(0, 0, 0, 0, 0, 1, 0, 0, 3);
    add(0, 0, 0, 0, 0, 1, 0, 0, 4);
    add(0, 0, 0, 0, 0, 1, 0, 0, 4);
    add(0, 0, 0, 0, 0, 0, 1, 0, 5);
    add(0, 0, 1, 0, 56'h01, 0, 1, 0, 5);
    add(0, 0, 1, 1, 56'h5F, 0, 1, 0, 5);
    add(0, 0, 1, 2, 56'h70, 0, 1, 0, 5);

    foreach (vecs[i]) begin
      START = vecs[i].start; ITER = vecs[i].iter;
      LOAD_EN = vecs[i].load_en; LOAD_ADDR = vecs[i].la; LOAD_DATA = vecs[i].ld;
      step();
      chk($sformatf("vec%0d_busy", i), 64'(BUSY), 64'(vecs[i].e_busy));
      chk($sformatf("vec%0d_done", i), 64'(DONE), 64'(vecs[i].e_done));
      chk($sformatf("vec%0d_valid", i), 64'(INST_VALID), 64'(vecs[i].e_valid));
      chk($sformatf("vec%0d_pass", i), 64'(PASS_CNT), 64'(vecs[i].e_pass));
    end
    START = 0; LOAD_EN = 0;

    // Three passes with READY held high.
    exp2 = '{56'h01, 56'h5F, 56'h01, 56'h5F, 56'h01, 56'h5F};
    START = 1; ITER = 3; step(); START = 0;
    for (int i = 0; i < 40; i++) begin
      if (INST_VALID && INST_READY) begin
        words.push_back(INST_OUT);
        tstamp.push_back(cyc);
      end
      if (DONE) break;
      step();
    end
    chk("p3_count", 64'(words.size()), 6);
    for (int i = 0; i < 6 && i < words.size(); i++) begin
      chk($sformatf("p3_word%0d", i), 64'(words[i]), 64'(exp2[i]));
      if (i > 0) chk($sformatf("p3_gap%0d", i), 64'(tstamp[i] - tstamp[i-1]), (i % 2) ? 64'd2 : 64'd4);
    end
    chk("p3_done", 64'(DONE), 1);
    chk("p3_pass", 64'(PASS_CNT), 3);

    // Backpressure on the first issue.
    INST_READY = 0; START = 1; ITER = 3; step(); START = 0;
    wait_for(0, 10, "bp_first");
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_hold_valid%0d", i), 64'(INST_VALID), 1);
      chk($sformatf("bp_hold_out%0d", i), 64'(INST_OUT), 64'h01);
      step();
    end
    INST_READY = 1; step();
    chk("bp_release_valid", 64'(INST_VALID), 0);
    wait_for(0, 10, "bp_next");
    chk("bp_next_out", 64'(INST_OUT), 64'h5F);
    step();
    wait_for(2, 40, "bp_done");
    chk("bp_pass", 64'(PASS_CNT), 3);

    // wfi program; early GO ignored; LOAD_EN while busy ignored.
    LOAD_EN = 1;
    LOAD_ADDR = 0; LOAD_DATA = 56'h01; step();
    LOAD_ADDR = 1; LOAD_DATA = 56'h60; step();
    LOAD_ADDR = 2; LOAD_DATA = 56'h5A; step();
    LOAD_ADDR = 3; LOAD_DATA = 56'h70; step();
    LOAD_EN = 0;
    START = 1; ITER = 1; GO = 1; step(); START = 0; GO = 0;
    wait_for(0, 10, "wfi_first");
    chk("wfi_first_out", 64'(INST_OUT), 64'h01);
    step();
    wait_for(1, 10, "wfi_wait");
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("wfi_hold_wait%0d", i), 64'(WAITING), 1);
      chk($sformatf("wfi_hold_valid%0d", i), 64'(INST_VALID), 0);
      LOAD_EN = (i == 3); LOAD_ADDR = 0; LOAD_DATA = 56'h0A;
      step();
    end
    LOAD_EN = 0;
    chk("wfi_busy", 64'(BUSY), 1);
    GO = 1; step(); GO = 0;
    chk("wfi_release", 64'(WAITING), 0);
    wait_for(0, 10, "wfi_after");
    chk("wfi_after_out", 64'(INST_OUT), 64'h5A);
    step();
    wait_for(2, 10, "wfi_done");
    chk("wfi_pass", 64'(PASS_CNT), 1);

    // Second run: entry 0 must still hold 56'h01.
    START = 1; ITER = 1; step(); START = 0;
    wait_for(0, 10, "rerun_first");
    chk("rerun_out", 64'(INST_OUT), 64'h01);
    step();
    wait_for(1, 10, "rerun_wait");
    GO = 1; step(); GO = 0;
    wait_for(0, 10, "rerun_5a");
    chk("rerun_5a_out", 64'(INST_OUT), 64'h5A);
    step();
    wait_for(2, 10, "rerun_done");

    // Reset while an instruction is pending.
    INST_READY = 0; START = 1; ITER = 2; step(); START = 0;
    wait_for(0, 10, "mid_valid");
    RESET = 1; step(); RESET = 0;
    chk("mid_rst_valid", 64'(INST_VALID), 0);
    chk("mid_rst_busy", 64'(BUSY), 0);
    chk("mid_rst_done", 64'(DONE), 0);
    chk("mid_rst_pass", 64'(PASS_CNT), 0);
    chk("mid_rst_out", 64'(INST_OUT), 0);
    INST_READY = 1;
    START = 1; ITER = 1; step(); START = 0;
    chk("empty_c1_done", 64'(DONE), 0);
    step();
    chk("empty_c2_valid", 64'(INST_VALID), 0);
    step();
    chk("empty_c3_done", 64'(DONE), 1);
    chk("empty_c3_pass", 64'(PASS_CNT), 1);

    // LOAD_EN together with START: first fetch sees the new word.
    LOAD_EN = 1; LOAD_ADDR = 0; LOAD_DATA = 56'h01; START = 1; ITER = 1;
    step(); LOAD_EN = 0; START = 0;
    wait_for(0, 10, "bypass_valid");
    chk("bypass_out", 64'(INST_OUT), 64'h01);
    step();
    wait_for(2, 10, "bypass_done");
    chk("bypass_pass", 64'(PASS_CNT), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
